// File: rtl/sdp_ram_32x4096.sv
// sdp_ram_32x4096
//   Simple dual-port RAM with one write port, one read port and a single clock.
//   The default size is 4096 x 32. It is meant to be inferred as block RAM and
//   serves as a FIFO backing store, a lookup table or scratch memory.
//
// Ports
//   clk         single clock; all logic runs on the rising edge
//   rst_n       synchronous active-low reset; clears the read register(s) only
//   wr_en       write strobe
//   wr_addr     write word address
//   wr_data     write data
//   wr_byte_en  per-byte write enables, honoured only when WR_BYTE_EN=1
//   rd_addr     read word address, sampled every cycle
//   rd_data     read data; latency is 1 (OUTPUT_REG=0) or 2 (OUTPUT_REG=1)
//
// Collision policy: a read and a write to the same address in the same cycle
// is read-first. The read returns the old word.

module sdp_ram_32x4096 #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter bit OUTPUT_REG = 1'b0,
  parameter bit WR_BYTE_EN = 1'b0,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // No reset on the array and no initialisation, so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // When byte enables are disabled, every lane is forced on.
  logic [BE_WIDTH-1:0] lane_en;
  assign lane_en = WR_BYTE_EN ? wr_byte_en : {BE_WIDTH{1'b1}};

  // Writes are gated by rst_n so a write cannot land while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (lane_en[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // This read register samples the pre-write contents because of NBA
  // ordering, which gives read-first behaviour on a same-address collision.
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= mem[rd_addr];
  end

  generate
    if (OUTPUT_REG) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_q2;

      always_ff @(posedge clk) begin
        if (!rst_n) rd_q2 <= '0;
        else        rd_q2 <= rd_q;
      end

      assign rd_data = rd_q2;
    end else begin : g_noreg
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_ram_32x4096.sv
// Testbench for sdp_ram_32x4096. Three instances share one stimulus stream:
//   dut0   default (latency 1, full-word writes)
//   dut_or OUTPUT_REG=1 (latency 2)
//   dut_be WR_BYTE_EN=1 (latency 1, byte-lane writes)
// Inputs change 1ns after the rising edge, and outputs are sampled at that point.

module tb_sdp_ram_32x4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic [11:0] rd_addr;
  logic [31:0] rd0, rd_or, rd_be;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sdp_ram_32x4096 dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_addr(rd_addr), .rd_data(rd0)
  );

  sdp_ram_32x4096 #(.OUTPUT_REG(1'b1)) dut_or (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_addr(rd_addr), .rd_data(rd_or)
  );

  sdp_ram_32x4096 #(.WR_BYTE_EN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_addr(rd_addr), .rd_data(rd_be)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Contents after the sweep: addr k (1..4095) holds FFFFFFFF-(k-1); addr 0 holds FFFFF000.
  function automatic logic [31:0] sweep_val(input logic [11:0] a);
    if (a == 12'd0) return 32'hFFFFF000;
    return 32'hFFFFFFFF - {20'd0, a} + 32'd1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_byte_en = 4'hF; rd_addr = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      total_cnt++;
      if (rd0 !== 32'h0 || rd_or !== 32'h0 || rd_be !== 32'h0)
        $display("FAIL reset_hold cyc=%0d got rd0=%h rd_or=%h rd_be=%h want 00000000", c, rd0, rd_or, rd_be);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    tick();
    // The output stage of the latency-2 instance still holds its reset value.
    total_cnt++;
    if (rd_or !== 32'h0) $display("FAIL reset_release rd_or got %h want 00000000", rd_or);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [12:0] a13;
    logic [11:0] cur, prev;
    wr_byte_en = 4'hF;
    for (int i = 0; i < 4096; i++) begin
      a13 = 13'(i + 1);
      wr_en = 1'b1;
      wr_addr = a13[11:0];            // 4096 truncates to 0
      wr_data = 32'hFFFFFFFF - 32'(i);
      tick();
    end
    wr_en = 1'b0;
    cur = '0;
    prev = '0;
    for (int i = 0; i <= 4096; i++) begin
      prev = cur;
      if (i < 4096) begin
        a13 = 13'(i + 1);
        cur = a13[11:0];
        rd_addr = cur;
      end
      tick();
      if (i < 4096) begin
        total_cnt++;
        if (rd0 !== sweep_val(cur) || rd_be !== sweep_val(cur))
          $display("FAIL sweep_rd addr=%0d got rd0=%h rd_be=%h want %h", cur, rd0, rd_be, sweep_val(cur));
        else pass_cnt++;
      end
      if (i >= 1) begin
        total_cnt++;
        if (rd_or !== sweep_val(prev))
          $display("FAIL sweep_rd_oreg addr=%0d got %h want %h", prev, rd_or, sweep_val(prev));
        else pass_cnt++;
      end
    end
    // Spot checks of the corner values called out for the sweep
    rd_addr = 12'd0; tick();
    total_cnt++;
    if (rd0 !== 32'hFFFFF000) $display("FAIL sweep_addr0 got %h want FFFFF000", rd0);
    else pass_cnt++;
    rd_addr = 12'd1; tick();
    total_cnt++;
    if (rd0 !== 32'hFFFFFFFF) $display("FAIL sweep_addr1 got %h want FFFFFFFF", rd0);
    else pass_cnt++;
    rd_addr = 12'd2; tick();
    total_cnt++;
    if (rd0 !== 32'hFFFFFFFE) $display("FAIL sweep_addr2 got %h want FFFFFFFE", rd0);
    else pass_cnt++;
  endtask

  task automatic test_wr_disable();
    wr_en = 1'b1; wr_addr = 12'd7; wr_data = 32'h00000007; wr_byte_en = 4'hF;
    tick();
    wr_en = 1'b0; wr_data = 32'hAAAAAAAA;
    tick();
    rd_addr = 12'd7;
    tick();
    total_cnt++;
    if (rd0 !== 32'h00000007 || rd_be !== 32'h00000007)
      $display("FAIL wr_disable got rd0=%h rd_be=%h want 00000007", rd0, rd_be);
    else pass_cnt++;
  endtask

  task automatic test_output_reg();
    // The previous cycle read addr 7, so one edge later the latency-2 output shows 7.
    rd_addr = 12'd1;
    tick();
    total_cnt++;
    if (rd_or !== 32'h00000007 || rd0 !== 32'hFFFFFFFF)
      $display("FAIL oreg_edge1 got rd_or=%h rd0=%h want 00000007/FFFFFFFF", rd_or, rd0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rd_or !== 32'hFFFFFFFF) $display("FAIL oreg_edge2 got %h want FFFFFFFF", rd_or);
    else pass_cnt++;
  endtask

  task automatic test_midstream_reset();
    rd_addr = 12'd2;
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 12'd1; wr_data = 32'h0; wr_byte_en = 4'hF;
    for (int c = 0; c < 2; c++) begin
      tick();
      total_cnt++;
      if (rd0 !== 32'h0 || rd_or !== 32'h0 || rd_be !== 32'h0)
        $display("FAIL mid_reset cyc=%0d got rd0=%h rd_or=%h rd_be=%h want 00000000", c, rd0, rd_or, rd_be);
      else pass_cnt++;
    end
    rst_n = 1'b1; wr_en = 1'b0; rd_addr = 12'd1;
    tick();
    total_cnt++;
    if (rd0 !== 32'hFFFFFFFF || rd_be !== 32'hFFFFFFFF)
      $display("FAIL mid_reset_data got rd0=%h rd_be=%h want FFFFFFFF", rd0, rd_be);
    else pass_cnt++;
    total_cnt++;
    if (rd_or !== 32'h0) $display("FAIL mid_reset_oreg1 got %h want 00000000", rd_or);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rd_or !== 32'hFFFFFFFF) $display("FAIL mid_reset_oreg2 got %h want FFFFFFFF", rd_or);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 12'd5; wr_data = 32'h12345678; wr_byte_en = 4'hF;
    tick();
    wr_data = 32'hDEADBEEF; rd_addr = 12'd5;
    tick();
    total_cnt++;
    if (rd0 !== 32'h12345678 || rd_be !== 32'h12345678)
      $display("FAIL collision_old got rd0=%h rd_be=%h want 12345678", rd0, rd_be);
    else pass_cnt++;
    wr_en = 1'b0;
    tick();
    total_cnt++;
    if (rd0 !== 32'hDEADBEEF) $display("FAIL collision_new got %h want DEADBEEF", rd0);
    else pass_cnt++;
    total_cnt++;
    if (rd_or !== 32'h12345678) $display("FAIL collision_oreg_old got %h want 12345678", rd_or);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rd_or !== 32'hDEADBEEF) $display("FAIL collision_oreg_new got %h want DEADBEEF", rd_or);
    else pass_cnt++;
  endtask

  task automatic test_byte_en();
    wr_en = 1'b1; wr_addr = 12'd3; wr_data = 32'h0; wr_byte_en = 4'hF;
    tick();
    wr_data = 32'h11223344; wr_byte_en = 4'b0101;
    tick();
    wr_en = 1'b0; rd_addr = 12'd3;
    tick();
    total_cnt++;
    if (rd_be !== 32'h00220044) $display("FAIL byte_en got %h want 00220044", rd_be);
    else pass_cnt++;
    // Byte enables are ignored on the full-word instance.
    total_cnt++;
    if (rd0 !== 32'h11223344) $display("FAIL byte_en_ignored got %h want 11223344", rd0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_wr_disable();
    test_output_reg();
    test_midstream_reset();
    test_collision();
    test_byte_en();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
